// File: rtl/fft16_stage_sequencer_if.sv
// Issue / write-back bus between the FFT stage sequencer and its datapath.
// The optional inverse-FFT pair exists only when FFT_INVERSE_EN is defined.
interface fft16_stage_sequencer_if #(
  parameter int AW = 4
);
  logic          i_start;
  logic          i_bf_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_bf_valid;
  logic [1:0]    o_stage;
  logic [AW-1:0] o_addr_a;
  logic [AW-1:0] o_addr_b;
  logic [2:0]    o_tw_idx;
  logic          o_wb_valid;
  logic [AW-1:0] o_wb_addr_a;
  logic [AW-1:0] o_wb_addr_b;
  logic [1:0]    o_dbg_state;
`ifdef FFT_INVERSE_EN
  logic          i_inverse;
  logic          o_tw_conj;
`endif

  // Handshake: an issue transfers in any cycle where o_bf_valid and i_bf_ready
  // are both high; while o_bf_valid is high and not taken, o_stage, o_addr_a,
  // o_addr_b and o_tw_idx stay stable. o_wb_valid has no ready: it is a strobe.
  modport master (
`ifdef FFT_INVERSE_EN
    input  i_inverse,
    output o_tw_conj,
`endif
    input  i_start, i_bf_ready,
    output o_busy, o_done, o_bf_valid, o_stage, o_addr_a, o_addr_b, o_tw_idx,
    output o_wb_valid, o_wb_addr_a, o_wb_addr_b, o_dbg_state
  );

  modport slave (
`ifdef FFT_INVERSE_EN
    output i_inverse,
    input  o_tw_conj,
`endif
    output i_start, i_bf_ready,
    input  o_busy, o_done, o_bf_valid, o_stage, o_addr_a, o_addr_b, o_tw_idx,
    input  o_wb_valid, o_wb_addr_a, o_wb_addr_b, o_dbg_state
  );
endinterface

// File: rtl/fft16_stage_sequencer.sv
// 16-point radix-2 DIT FFT control: 4 stages x 8 butterflies, write-back tracking
// and a drain barrier between stages. FFT_INVERSE_EN adds the conj-twiddle flag.
module fft16_stage_sequencer #(
  parameter int BF_LAT = 3,
  parameter int AW     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  fft16_stage_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic          vld;
    logic          last;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
  } wb_t;

  state_e        state_q, state_d;
  logic [1:0]    stage_q, stage_d;
  logic [2:0]    bf_q, bf_d;
  wb_t           wb_q [BF_LAT];
  wb_t           wb_in;
  wb_t           wb_out;
  logic          accept;
  logic          stage_last_wb;
  logic [AW-1:0] dec_a, dec_b;
  logic [2:0]    dec_tw;

  assign accept        = (state_q == S_ISSUE) && bus.i_bf_ready;
  assign wb_out        = wb_q[BF_LAT-1];
  assign stage_last_wb = wb_out.vld && wb_out.last;

  // Stage s inserts a zero at address bit s (upper operand) or a one (lower);
  // the twiddle index is the in-group position scaled up to the 16-point grid.
  always_comb begin : decode
    dec_a  = '0;
    dec_b  = '0;
    dec_tw = '0;
    unique case (stage_q)
      2'd0: begin
        dec_a  = {bf_q, 1'b0};
        dec_b  = {bf_q, 1'b1};
        dec_tw = 3'd0;
      end
      2'd1: begin
        dec_a  = {bf_q[2:1], 1'b0, bf_q[0]};
        dec_b  = {bf_q[2:1], 1'b1, bf_q[0]};
        dec_tw = {bf_q[0], 2'b00};
      end
      2'd2: begin
        dec_a  = {bf_q[2], 1'b0, bf_q[1:0]};
        dec_b  = {bf_q[2], 1'b1, bf_q[1:0]};
        dec_tw = {bf_q[1:0], 1'b0};
      end
      2'd3: begin
        dec_a  = {1'b0, bf_q};
        dec_b  = {1'b1, bf_q};
        dec_tw = bf_q;
      end
    endcase
  end

  always_comb begin : fsm_next
    state_d = state_q;
    stage_d = stage_q;
    bf_d    = bf_q;
    case (state_q)
      S_IDLE: begin
        stage_d = '0;
        bf_d    = '0;
        if (bus.i_start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (accept) begin
          if (bf_q == 3'd7) state_d = S_DRAIN;
          else              bf_d    = bf_q + 3'd1;
        end
      end
      S_DRAIN: begin
        if (stage_last_wb) begin
          if (stage_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + 2'd1;
            bf_d    = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        stage_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The last butterfly of each stage carries a tag so DRAIN knows when to release.
  always_comb begin : wb_entry
    wb_in        = '0;
    wb_in.vld    = accept;
    wb_in.last   = accept && (bf_q == 3'd7);
    wb_in.addr_a = accept ? dec_a : '0;
    wb_in.addr_b = accept ? dec_b : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      bf_q    <= '0;
      for (int i = 0; i < BF_LAT; i++) wb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bf_q    <= bf_d;
      wb_q[0] <= wb_in;
      for (int i = 1; i < BF_LAT; i++) wb_q[i] <= wb_q[i-1];
    end
  end

  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_done      = (state_q == S_DONE);
  assign bus.o_bf_valid  = (state_q == S_ISSUE);
  assign bus.o_stage     = stage_q;
  assign bus.o_addr_a    = bus.o_bf_valid ? dec_a  : '0;
  assign bus.o_addr_b    = bus.o_bf_valid ? dec_b  : '0;
  assign bus.o_tw_idx    = bus.o_bf_valid ? dec_tw : '0;
  assign bus.o_wb_valid  = wb_out.vld;
  assign bus.o_wb_addr_a = wb_out.addr_a;
  assign bus.o_wb_addr_b = wb_out.addr_b;
  assign bus.o_dbg_state = state_q;

`ifdef FFT_INVERSE_EN
  logic conj_q, conj_d;

  always_comb begin : conj_next
    conj_d = conj_q;
    if (state_q == S_IDLE)      conj_d = bus.i_start & bus.i_inverse;
    else if (state_q == S_DONE) conj_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) conj_q <= 1'b0;
    else       conj_q <= conj_d;
  end

  assign bus.o_tw_conj = conj_q;
`endif

endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Bench for fft16_stage_sequencer: issue model plus a write-back scoreboard.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
module tb_fft16_stage_sequencer;
  localparam int BF_LAT   = 3;
  localparam int AW       = 4;
  localparam int STAGE_P  = 8 + BF_LAT;
  localparam int LAST_WB  = 1 + 3 * STAGE_P + 7 + BF_LAT;
  localparam int DONE_CYC = LAST_WB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  fft16_stage_sequencer_if #(.AW(AW)) bus ();

  fft16_stage_sequencer #(.BF_LAT(BF_LAT), .AW(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [2*AW-1:0] exp_q[$];
  int              exp_cyc_q[$];
  bit              mon_en = 1'b0;
  int              t0 = 0;
  int              issue_n, wb_n, done_n, first_done, first_busy, last_busy;
  int              acc_cyc [32];

  function automatic void model(input int s, input int b, output logic [AW-1:0] a,
                                output logic [AW-1:0] bb, output logic [2:0] tw);
    int half, pos, grp, ai;
    half = 1 << s;
    pos  = b & (half - 1);
    grp  = b >> s;
    ai   = grp * 2 * half + pos;
    a    = AW'(ai);
    bb   = AW'(ai + half);
    tw   = 3'((pos << (3 - s)) & 7);
  endfunction

  always @(negedge clk) begin
    int              rel, ec;
    logic [AW-1:0]   ea, eb;
    logic [2:0]      et;
    logic [1:0]      es;
    logic [2*AW-1:0] e;
    if (mon_en) begin
      rel = cyc - t0;
      if (bus.o_bf_valid === 1'b1) begin
        es = 2'((issue_n % 32) / 8);
        model(int'(es), issue_n % 8, ea, eb, et);
        checks++;
        if ({bus.o_stage, bus.o_addr_a, bus.o_addr_b, bus.o_tw_idx} !== {es, ea, eb, et}) begin
          failures++;
          $display("FAIL issue n=%0d cyc=%0d got s=%0d a=%0d b=%0d tw=%0d exp s=%0d a=%0d b=%0d tw=%0d",
                   issue_n, rel, bus.o_stage, bus.o_addr_a, bus.o_addr_b, bus.o_tw_idx, es, ea, eb, et);
        end
        if (bus.i_bf_ready === 1'b1) begin
          exp_q.push_back({ea, eb});
          exp_cyc_q.push_back(rel + BF_LAT);
          acc_cyc[issue_n % 32] = rel;
          issue_n++;
        end
      end
      if (bus.o_wb_valid === 1'b1) begin
        checks++;
        wb_n++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_spurious cyc=%0d got a=%0d b=%0d exp none", rel, bus.o_wb_addr_a, bus.o_wb_addr_b);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if ({bus.o_wb_addr_a, bus.o_wb_addr_b} !== e || rel != ec) begin
            failures++;
            $display("FAIL wb cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d at cyc=%0d",
                     rel, bus.o_wb_addr_a, bus.o_wb_addr_b, e[2*AW-1:AW], e[AW-1:0], ec);
          end
        end
      end
      if (bus.o_done === 1'b1) begin
        if (done_n == 0) first_done = rel;
        done_n++;
      end
      if (bus.o_busy === 1'b1) begin
        if (first_busy < 0) first_busy = rel;
        last_busy = rel;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    exp_q.delete();
    exp_cyc_q.delete();
    issue_n = 0; wb_n = 0; done_n = 0;
    first_done = -1; first_busy = -1; last_busy = -1;
    for (int i = 0; i < 32; i++) acc_cyc[i] = -1;
  endtask

  task automatic start_run();
    tick();
    clear_mon();
    t0 = cyc;
    bus.i_start = 1'b1;
    mon_en = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input int n_done, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_n >= n_done && bus.o_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_bf_valid, bus.o_stage, bus.o_addr_a, bus.o_addr_b, bus.o_tw_idx,
         bus.o_wb_valid, bus.o_wb_addr_a, bus.o_wb_addr_b, bus.o_dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b bfv=%b wbv=%b a=%0d b=%0d exp all zero",
               bus.o_busy, bus.o_bf_valid, bus.o_wb_valid, bus.o_addr_a, bus.o_addr_b);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.o_busy, bus.o_bf_valid, bus.o_done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b bfv=%b done=%b exp 000", bus.o_busy, bus.o_bf_valid, bus.o_done);
    end
  endtask

  task automatic test_full_run();
    bit ok;
    bus.i_bf_ready = 1'b1;
    start_run();
    wait_idle(1, 150, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got busy=%b exp idle", bus.o_busy); end
    checks++; if (issue_n != 32) begin failures++; $display("FAIL full_issues got=%0d exp=32", issue_n); end
    checks++; if (wb_n != 32) begin failures++; $display("FAIL full_wbs got=%0d exp=32", wb_n); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_pending got=%0d exp=0", exp_q.size()); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_n); end
    checks++; if (first_done != DONE_CYC) begin failures++; $display("FAIL full_done_cyc got=%0d exp=%0d", first_done, DONE_CYC); end
    checks++; if (first_busy != 1) begin failures++; $display("FAIL full_busy_rise got=%0d exp=1", first_busy); end
    checks++; if (last_busy != DONE_CYC) begin failures++; $display("FAIL full_busy_last got=%0d exp=%0d", last_busy, DONE_CYC); end
    checks++; if (acc_cyc[0] != 1) begin failures++; $display("FAIL full_first_issue got=%0d exp=1", acc_cyc[0]); end
    checks++; if (acc_cyc[7] != 8) begin failures++; $display("FAIL full_s0_last got=%0d exp=8", acc_cyc[7]); end
    checks++; if (acc_cyc[8] != 1 + STAGE_P) begin failures++; $display("FAIL full_s1_first got=%0d exp=%0d", acc_cyc[8], 1 + STAGE_P); end
    checks++; if (acc_cyc[16] != 1 + 2 * STAGE_P) begin failures++; $display("FAIL full_s2_first got=%0d exp=%0d", acc_cyc[16], 1 + 2 * STAGE_P); end
    checks++; if (acc_cyc[31] != 1 + 3 * STAGE_P + 7) begin failures++; $display("FAIL full_s3_last got=%0d exp=%0d", acc_cyc[31], 1 + 3 * STAGE_P + 7); end
    mon_en = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.i_bf_ready = 1'b1;
    start_run();
    for (int i = 0; i < 40 && issue_n < 10; i++) tick();
    checks++; if (issue_n != 10) begin failures++; $display("FAIL bp_reach got=%0d exp=10", issue_n); end
    bus.i_bf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.o_bf_valid !== 1'b1 || issue_n != 10) begin
        failures++;
        $display("FAIL bp_hold got bfv=%b n=%0d exp bfv=1 n=10", bus.o_bf_valid, issue_n);
      end
      tick();
    end
    bus.i_bf_ready = 1'b1;
    wait_idle(1, 150, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got busy=%b exp idle", bus.o_busy); end
    checks++; if (acc_cyc[10] != 19) begin failures++; $display("FAIL bp_resume got=%0d exp=19", acc_cyc[10]); end
    checks++; if (acc_cyc[16] != 1 + 2 * STAGE_P + 5) begin failures++; $display("FAIL bp_s2_first got=%0d exp=%0d", acc_cyc[16], 1 + 2 * STAGE_P + 5); end
    checks++; if (first_done != DONE_CYC + 5) begin failures++; $display("FAIL bp_done_cyc got=%0d exp=%0d", first_done, DONE_CYC + 5); end
    checks++; if (issue_n != 32 || wb_n != 32) begin failures++; $display("FAIL bp_counts got=%0d/%0d exp=32/32", issue_n, wb_n); end
    mon_en = 1'b0;
  endtask

  task automatic test_start_while_busy();
    bit ok;
    bus.i_bf_ready = 1'b1;
    start_run();
    while (cyc - t0 < 10) tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    while (cyc - t0 < 30) tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    while (cyc - t0 < 44) tick();
    bus.i_start = 1'b1;
    while (cyc - t0 < 48) tick();
    bus.i_start = 1'b0;
    checks++; if (done_n != 1 || first_done != DONE_CYC) begin failures++; $display("FAIL busy_single_done got n=%0d cyc=%0d exp n=1 cyc=%0d", done_n, first_done, DONE_CYC); end
    checks++; if (acc_cyc[0] != DONE_CYC + 2) begin failures++; $display("FAIL busy_relaunch got=%0d exp=%0d", acc_cyc[0], DONE_CYC + 2); end
    wait_idle(2, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL busy_timeout got busy=%b exp idle", bus.o_busy); end
    checks++; if (issue_n != 64 || wb_n != 64) begin failures++; $display("FAIL busy_counts got=%0d/%0d exp=64/64", issue_n, wb_n); end
    checks++; if (done_n != 2) begin failures++; $display("FAIL busy_done_count got=%0d exp=2", done_n); end
    mon_en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int wbs, iss;
    bus.i_bf_ready = 1'b1;
    start_run();
    while (cyc - t0 < 20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_bf_valid, bus.o_stage, bus.o_addr_a, bus.o_addr_b, bus.o_tw_idx,
         bus.o_wb_valid, bus.o_wb_addr_a, bus.o_wb_addr_b} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got busy=%b bfv=%b wbv=%b stage=%0d exp all zero",
               bus.o_busy, bus.o_bf_valid, bus.o_wb_valid, bus.o_stage);
    end
    wbs = wb_n;
    iss = issue_n;
    repeat (20) tick();
    checks++; if (wb_n != wbs) begin failures++; $display("FAIL midrst_wb got=%0d exp=%0d", wb_n, wbs); end
    checks++; if (issue_n != iss) begin failures++; $display("FAIL midrst_issue got=%0d exp=%0d", issue_n, iss); end
    checks++; if (done_n != 0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", done_n); end
    start_run();
    wait_idle(1, 150, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout got busy=%b exp idle", bus.o_busy); end
    checks++; if (issue_n != 32 || wb_n != 32) begin failures++; $display("FAIL midrst_rerun got=%0d/%0d exp=32/32", issue_n, wb_n); end
    checks++; if (first_done != DONE_CYC) begin failures++; $display("FAIL midrst_rerun_done got=%0d exp=%0d", first_done, DONE_CYC); end
    mon_en = 1'b0;
  endtask

`ifdef FFT_INVERSE_EN
  task automatic test_inverse();
    logic e;
    bus.i_bf_ready = 1'b1;
    bus.i_inverse  = 1'b1;
    start_run();
    bus.i_inverse  = 1'b0;
    while (cyc - t0 <= DONE_CYC + 1) begin
      e = (cyc - t0 <= DONE_CYC);
      checks++;
      if (bus.o_tw_conj !== e) begin
        failures++;
        $display("FAIL tw_conj cyc=%0d got=%b exp=%b", cyc - t0, bus.o_tw_conj, e);
      end
      tick();
    end
    mon_en = 1'b0;
  endtask
`endif

  initial begin
    bus.i_start    = 1'b0;
    bus.i_bf_ready = 1'b1;
`ifdef FFT_INVERSE_EN
    bus.i_inverse  = 1'b0;
`endif
    clear_mon();
    test_reset();
    test_full_run();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef FFT_INVERSE_EN
    test_inverse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
